// File: rtl/sc_spi_target.sv
// ============================================================================
// Module      : sc_spi_target
// Description : SPI target engine. Oversamples SCLK/CSB/MOSI on SYSCLK, all
//               four CPOL/CPHA modes, 2..32-bit MSB-first words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic [4:0]  DWIDTH,
  input  logic [31:0] TXDATA,
  output logic        TXLOAD,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic        BUSY,
  output logic        FRMERR,
  input  logic        SCLK,
  input  logic        CSB,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csb_sync, r_mosi_sync;
  logic                   r_sclk_d, r_csb_d;

  // CSB synchronizer resets low so a CSB already low at release is not a fall.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_csb_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], CSB};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_csb_d     <= r_csb_sync[SYNC_STAGES-1];
    end
  end

  state_t      r_state;
  logic        r_cpha, r_smp_rise;
  logic [4:0]  r_dw, r_bc;
  logic [31:0] r_tx, r_rx, r_rxdata;
  logic        r_done, r_reload, r_skip;
  logic        r_miso, r_txload, r_rxvalid, r_busy, r_frmerr;

  logic        w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;
  logic        w_smp, w_shf, w_last;
  logic [4:0]  w_dw_in;
  logic [31:0] w_mask;

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
  assign w_csb_rise  = r_csb_sync[SYNC_STAGES-1] & ~r_csb_d;
  assign w_csb_fall  = ~r_csb_sync[SYNC_STAGES-1] & r_csb_d;
  assign w_smp       = r_smp_rise ? w_sclk_rise : w_sclk_fall;
  assign w_shf       = r_smp_rise ? w_sclk_fall : w_sclk_rise;
  assign w_last      = (r_bc == r_dw);
  assign w_dw_in     = (DWIDTH == 5'd0) ? 5'd1 : DWIDTH;
  assign w_mask      = 32'hFFFF_FFFF >> (5'd31 - r_dw);

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_state    <= ST_IDLE;
      r_cpha     <= 1'b0;
      r_smp_rise <= 1'b1;
      r_dw       <= 5'd1;
      r_bc       <= 5'd0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rxdata   <= '0;
      r_done     <= 1'b0;
      r_reload   <= 1'b0;
      r_skip     <= 1'b0;
      r_miso     <= 1'b0;
      r_txload   <= 1'b0;
      r_rxvalid  <= 1'b0;
      r_busy     <= 1'b0;
      r_frmerr   <= 1'b0;
    end else begin
      r_txload  <= 1'b0;
      r_rxvalid <= 1'b0;
      r_frmerr  <= 1'b0;
      r_done    <= 1'b0;
      if (r_done) begin
        r_rxvalid <= 1'b1;
        r_rxdata  <= r_rx & w_mask;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_csb_fall) begin
            r_state    <= ST_ACTIVE;
            r_cpha     <= CPHA;
            r_smp_rise <= ~(CPOL ^ CPHA);
            r_dw       <= w_dw_in;
            r_tx       <= TXDATA;
            r_txload   <= 1'b1;
            r_bc       <= 5'd0;
            r_busy     <= 1'b1;
            r_skip     <= 1'b0;
            r_reload   <= 1'b0;
            r_miso     <= CPHA ? 1'b0 : TXDATA[w_dw_in];
          end
        end
        default: begin
          if (w_smp) begin
            r_rx <= {r_rx[30:0], r_mosi_sync[SYNC_STAGES-1]};
            if (w_last) begin
              r_bc     <= 5'd0;
              r_done   <= 1'b1;
              r_reload <= r_cpha;
            end else begin
              r_bc <= r_bc + 5'd1;
            end
          end
          if (w_csb_rise) begin
            // A word completing on the same cycle as CSB rise is not an error.
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_miso   <= 1'b0;
            r_bc     <= 5'd0;
            r_reload <= 1'b0;
            r_frmerr <= w_smp ? ~w_last : (r_bc != 5'd0);
          end else if (r_done && !r_cpha) begin
            // CPHA=0: next word's MSB must be on MISO before its first sample
            // edge, so load now and swallow the trailing shift edge.
            r_tx     <= TXDATA;
            r_miso   <= TXDATA[r_dw];
            r_txload <= 1'b1;
            r_skip   <= 1'b1;
          end else if (w_shf) begin
            if (r_cpha) begin
              if (r_reload) begin
                r_tx     <= TXDATA << 1;
                r_miso   <= TXDATA[r_dw];
                r_txload <= 1'b1;
                r_reload <= 1'b0;
              end else begin
                r_tx   <= r_tx << 1;
                r_miso <= r_tx[r_dw];
              end
            end else if (r_skip) begin
              r_skip <= 1'b0;
            end else begin
              r_tx   <= r_tx << 1;
              r_miso <= r_tx[r_dw - 5'd1];
            end
          end
        end
      endcase
    end
  end

  assign TXLOAD  = r_txload;
  assign RXDATA  = r_rxdata;
  assign RXVALID = r_rxvalid;
  assign BUSY    = r_busy;
  assign FRMERR  = r_frmerr;
  assign MISO    = r_miso;
  assign MISO_OE = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sc_spi_target.sv
// ============================================================================
// Module      : tb_sc_spi_target
// Description : Self-checking bench for sc_spi_target with an SPI controller
//               model and word-level expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_spi_target;

  logic        SYSCLK = 1'b0;
  logic        SYSRST;
  logic        CPOL, CPHA;
  logic [4:0]  DWIDTH;
  logic [31:0] TXDATA;
  logic        TXLOAD;
  logic [31:0] RXDATA;
  logic        RXVALID, BUSY, FRMERR;
  logic        SCLK, CSB, MOSI, MISO, MISO_OE;

  always #5 SYSCLK = ~SYSCLK;

  sc_spi_target #(.SYNC_STAGES(2)) dut (
    .SYSCLK (SYSCLK),
    .SYSRST (SYSRST),
    .CPOL   (CPOL),
    .CPHA   (CPHA),
    .DWIDTH (DWIDTH),
    .TXDATA (TXDATA),
    .TXLOAD (TXLOAD),
    .RXDATA (RXDATA),
    .RXVALID(RXVALID),
    .BUSY   (BUSY),
    .FRMERR (FRMERR),
    .SCLK   (SCLK),
    .CSB    (CSB),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .MISO_OE(MISO_OE)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] m_tx [4];
  logic [31:0] m_mosi [3];
  logic [31:0] m_miso [3];
  logic [31:0] rx_q [$];
  int tx_total = 0, tx0 = 0, tx_at_rx = 0, frm_total = 0, mon_idx;

  // Parallel-side consumer/producer: logs RX words and feeds the next TX word.
  always @(negedge SYSCLK) begin
    if (RXVALID) begin
      rx_q.push_back(RXDATA);
      tx_at_rx = tx_total;
    end
    if (FRMERR) frm_total++;
    if (TXLOAD) tx_total++;
    mon_idx = tx_total - tx0;
    if (mon_idx > 3) mon_idx = 3;
    TXDATA = m_tx[mon_idx];
  end

  function automatic logic [31:0] mask(input int dw);
    return 32'hFFFF_FFFF >> (31 - dw);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // Controller: nw words of DWIDTH, half-period h SYSCLKs; abort_bits>0 ends early.
  task automatic run_frame(input logic [1:0] mode, input int dw_in, input int nw,
                           input int h, input int abort_bits);
    int dw, bits, total, f0, wi, bi;
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    dw    = (dw_in == 0) ? 1 : dw_in;
    bits  = dw + 1;
    total = (abort_bits > 0) ? abort_bits : nw * bits;
    CPOL = cpol; CPHA = cpha; DWIDTH = dw_in[4:0]; SCLK = cpol;
    tick(h);
    rx_q.delete();
    tx0 = tx_total;
    f0  = frm_total;
    for (int i = 0; i < 3; i++) m_miso[i] = '0;
    MOSI = m_mosi[0][dw];
    CSB  = 1'b0;
    tick(h + 1);
    for (int k = 0; k < total; k++) begin
      wi = k / bits;
      bi = dw - (k % bits);
      if (!cpha) begin
        m_miso[wi] = {m_miso[wi][30:0], MISO};
        SCLK = ~cpol;
        tick(h);
        SCLK = cpol;
        if (k + 1 < total) MOSI = m_mosi[(k + 1) / bits][dw - ((k + 1) % bits)];
        tick(h);
      end else begin
        SCLK = ~cpol;
        MOSI = m_mosi[wi][bi];
        tick(h);
        m_miso[wi] = {m_miso[wi][30:0], MISO};
        SCLK = cpol;
        tick(h);
      end
      if (k == 0) check("busy_oe_active", {30'd0, BUSY, MISO_OE}, 32'd3);
    end
    CSB = 1'b1;
    tick(h + 6);
    check("idle_busy_oe_miso", {29'd0, BUSY, MISO_OE, MISO}, 32'd0);
    if (abort_bits > 0) begin
      check("frmerr_count", frm_total - f0, 1);
      check("rx_count_abort", rx_q.size(), 0);
    end else begin
      check("frmerr_none", frm_total - f0, 0);
      check("rx_count", rx_q.size(), nw);
      for (int i = 0; i < nw; i++) begin
        if (i < rx_q.size()) check($sformatf("rxdata_w%0d", i), rx_q[i], m_mosi[i] & mask(dw));
        check($sformatf("miso_w%0d", i), m_miso[i], m_tx[i] & mask(dw));
      end
      check("txload_count", tx_at_rx - tx0, nw);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_tx[i] = '0;
    for (int i = 0; i < 3; i++) m_mosi[i] = '0;
    SYSRST = 1'b1; CSB = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7;
    tick(4);
    check("reset_ctrl", {26'd0, TXLOAD, RXVALID, BUSY, FRMERR, MISO, MISO_OE}, 32'd0);
    check("reset_rxdata", RXDATA, 32'd0);
    SYSRST = 1'b0;
    tick(6);

    // Mode 0, 8-bit
    m_tx[0] = 32'h0000_00A5; m_mosi[0] = 32'h3C;
    run_frame(2'd0, 7, 1, 4, 0);

    // Modes 1..3, 16-bit
    for (int m = 1; m < 4; m++) begin
      m_tx[0] = 32'hBEEF; m_mosi[0] = 32'h1234;
      run_frame(m[1:0], 15, 1, 4, 0);
    end

    // Mode 0, three back-to-back 32-bit words
    m_tx[0] = 32'h1111_1111; m_tx[1] = 32'h2222_2222; m_tx[2] = 32'h3333_3333; m_tx[3] = 32'h0;
    m_mosi[0] = 32'hDEAD_BEEF; m_mosi[1] = 32'h0123_4567; m_mosi[2] = 32'h89AB_CDEF;
    run_frame(2'd0, 31, 3, 4, 0);

    // Partial word then a clean frame
    m_tx[0] = 32'h5A; m_mosi[0] = 32'hFF;
    run_frame(2'd0, 7, 1, 4, 5);
    m_tx[0] = 32'h66; m_mosi[0] = 32'h81;
    run_frame(2'd0, 7, 1, 4, 0);

    // Reset mid-frame with CSB held low
    CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7; SCLK = 1'b0;
    CSB = 1'b0;
    tick(5);
    for (int k = 0; k < 3; k++) begin SCLK = 1'b1; tick(4); SCLK = 1'b0; tick(4); end
    SYSRST = 1'b1;
    tick(2);
    check("midreset_ctrl", {26'd0, TXLOAD, RXVALID, BUSY, FRMERR, MISO, MISO_OE}, 32'd0);
    check("midreset_rxdata", RXDATA, 32'd0);
    SYSRST = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 8; k++) begin SCLK = 1'b1; tick(4); SCLK = 1'b0; tick(4); end
    tick(4);
    check("postreset_no_rx", rx_q.size(), 0);
    check("postreset_busy", {31'd0, BUSY}, 32'd0);
    CSB = 1'b1;
    tick(8);
    m_tx[0] = 32'hC3; m_mosi[0] = 32'h7E;
    run_frame(2'd0, 7, 1, 4, 0);

    // 2-bit words at the fastest SCLK
    m_tx[0] = 32'h1; m_mosi[0] = 32'h2;
    run_frame(2'd0, 1, 1, 3, 0);

    // Random frames (DWIDTH 0 exercises the treated-as-1 rule)
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 4; i++) m_tx[i] = $urandom;
      for (int i = 0; i < 3; i++) m_mosi[i] = $urandom;
      run_frame(2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(1, 3),
                $urandom_range(3, 6), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
